dmem_bus_responder: RTL and testbench

//  Data-side memory responder for the EX-stage request port (req/addr/wdata/byte-enables).

---
 rtl/dmem_bus_responder_pkg.sv | 20 ++
 rtl/dmem_bus_responder_wbuf.sv | 41 ++++
 rtl/dmem_bus_responder.sv | 174 +++++++++++++++++
 tb/tb_dmem_bus_responder.sv | 281 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dmem_bus_responder_pkg.sv
// Shared definitions for the data-side memory responder.
//   dmemStateT   : responder FSM states
//   DMEM_BE_READ : byte enables driven on bus reads
//   wordAddr()   : rebuilds a word-aligned byte address from a word index
package dmem_bus_responder_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RD_WAIT = 2'd1,
    RD_DONE = 2'd2,
    WR_WAIT = 2'd3
  } dmemStateT;

  localparam logic [3:0] DMEM_BE_READ = 4'b1111;

  function automatic logic [31:0] wordAddr(input logic [29:0] wordIdx);
    return {wordIdx, 2'b00};
  endfunction

endpackage

// File: rtl/dmem_bus_responder_wbuf.sv
// One-entry posted-store buffer.
//   clk, rst        : clock, synchronous active-high reset
//   load            : capture loadAddr/loadData/loadBe and mark valid
//   clear           : drop the entry once the bus has taken it
//   loadAddr[31:2]  : store word index
//   loadData/loadBe : store data and byte enables
//   addr/data/be    : buffered store (addr word-aligned)
//   valid           : entry occupied
module dmem_wbuf
  import dmem_bus_responder_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        load,
  input  logic        clear,
  input  logic [29:0] loadAddr,
  input  logic [31:0] loadData,
  input  logic [3:0]  loadBe,
  output logic [31:0] addr,
  output logic [31:0] data,
  output logic [3:0]  be,
  output logic        valid
);

  always_ff @(posedge clk) begin
    if (rst) begin
      valid <= 1'b0;
      addr  <= '0;
      data  <= '0;
      be    <= '0;
    end else if (load) begin
      valid <= 1'b1;
      addr  <= wordAddr(loadAddr);
      data  <= loadData;
      be    <= loadBe;
    end else if (clear) begin
      valid <= 1'b0;
    end
  end

endmodule

// File: rtl/dmem_bus_responder.sv
// Data-side memory responder between the EX-stage request port and a
// single-outstanding req/ack data bus. Stores are posted through a 1-entry
// write buffer; loads stall the pipeline until bus data is registered.
// Accesses that see no ack for TIMEOUT bus cycles are aborted with an error.
//   clk, rst           : clock, synchronous active-high reset
//   cpu_req/cpu_kill   : request, and fault that cancels it
//   cpu_addr/cpu_wdata : byte address, lane-rotated store data
//   cpu_we             : byte enables, 4'b0000 = load
//   cpu_rdata          : load data, valid in the cycle cpu_stall falls
//   cpu_stall          : combinational EX-stage hold
//   cpu_err            : one-cycle pulse on a failed load or posted store
//   bus_req..bus_wdata : registered request, stable while bus_req=1
//   bus_ack/bus_err    : completion / failure, bus_rdata valid with ack
module dmem_bus_responder #(
  parameter int unsigned TIMEOUT   = 256,
  parameter logic [31:0] ERR_RDATA = 32'h00000000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cpu_req,
  input  logic        cpu_kill,
  input  logic [31:0] cpu_addr,
  input  logic [31:0] cpu_wdata,
  input  logic [3:0]  cpu_we,
  output logic [31:0] cpu_rdata,
  output logic        cpu_stall,
  output logic        cpu_err,
  output logic        bus_req,
  output logic        bus_we,
  output logic [31:0] bus_addr,
  output logic [3:0]  bus_be,
  output logic [31:0] bus_wdata,
  input  logic        bus_ack,
  input  logic        bus_err,
  input  logic [31:0] bus_rdata
);
  import dmem_bus_responder_pkg::*;

  localparam int unsigned CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

  dmemStateT     state, nextState;
  logic          busReqQ;
  logic [31:0]   rdAddr;
  logic [31:0]   rdataQ;
  logic          errQ;
  logic [CW-1:0] cnt;

  logic [31:0] wbAddr, wbData;
  logic [3:0]  wbBe;
  logic        wbValid, wbLoad, wbClear;

  logic valid, isLoad, isStore;
  logic timedOut, finish, failed;
  logic stallComb, startRead, complete;
  logic isWrite;
  logic unusedAddrLsb;

  assign unusedAddrLsb = ^cpu_addr[1:0];

  assign valid   = cpu_req & ~cpu_kill;
  assign isLoad  = valid & (cpu_we == 4'b0000);
  assign isStore = valid & (cpu_we != 4'b0000);

  // Ack arriving on the last counted cycle wins over the timeout.
  assign timedOut = (cnt == CNT_LAST);
  assign finish   = bus_ack | bus_err | timedOut;
  assign failed   = bus_err | (timedOut & ~bus_ack);

  dmem_wbuf u_wbuf (
    .clk      (clk),
    .rst      (rst),
    .load     (wbLoad),
    .clear    (wbClear),
    .loadAddr (cpu_addr[31:2]),
    .loadData (cpu_wdata),
    .loadBe   (cpu_we),
    .addr     (wbAddr),
    .data     (wbData),
    .be       (wbBe),
    .valid    (wbValid)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= nextState;
    end
  end

  always_comb begin
    nextState = state;
    stallComb = 1'b0;
    startRead = 1'b0;
    wbLoad    = 1'b0;
    wbClear   = 1'b0;
    complete  = 1'b0;
    unique case (state)
      IDLE: begin
        if (isStore && !wbValid) begin
          wbLoad    = 1'b1;
          nextState = WR_WAIT;
        end else if (isStore) begin
          stallComb = 1'b1;
        end else if (isLoad) begin
          stallComb = 1'b1;
          startRead = 1'b1;
          nextState = RD_WAIT;
        end
      end
      RD_WAIT: begin
        stallComb = 1'b1;
        if (finish) begin
          complete  = 1'b1;
          nextState = RD_DONE;
        end
      end
      RD_DONE: begin
        nextState = IDLE;
      end
      WR_WAIT: begin
        // No forwarding from the buffer: every request waits for the drain.
        stallComb = valid;
        if (finish) begin
          complete  = 1'b1;
          wbClear   = 1'b1;
          nextState = IDLE;
        end
      end
      default: nextState = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      busReqQ <= 1'b0;
      rdAddr  <= '0;
      rdataQ  <= '0;
      errQ    <= 1'b0;
      cnt     <= '0;
    end else begin
      errQ <= complete & failed;
      if (startRead || wbLoad) begin
        busReqQ <= 1'b1;
        cnt     <= '0;
      end else if (complete) begin
        busReqQ <= 1'b0;
      end else if (busReqQ && !bus_ack && (cnt != CNT_LAST)) begin
        cnt <= cnt + CW'(1);
      end
      if (startRead) begin
        rdAddr <= wordAddr(cpu_addr[31:2]);
      end
      if (complete && (state == RD_WAIT)) begin
        rdataQ <= failed ? ERR_RDATA : bus_rdata;
      end
    end
  end

  // Write fields come straight from the store buffer and read fields from
  // rdAddr, selected by state; everything is forced to zero while idle.
  assign isWrite   = (state == WR_WAIT);
  assign bus_req   = busReqQ;
  assign bus_we    = busReqQ & isWrite;
  assign bus_addr  = !busReqQ ? '0 : (isWrite ? wbAddr : rdAddr);
  assign bus_be    = !busReqQ ? '0 : (isWrite ? wbBe : DMEM_BE_READ);
  assign bus_wdata = (busReqQ && isWrite) ? wbData : '0;

  assign cpu_rdata = rdataQ;
  assign cpu_stall = stallComb;
  assign cpu_err   = errQ;

endmodule

// File: tb/tb_dmem_bus_responder.sv
module tb_dmem_bus_responder;

  localparam int unsigned TO   = 8;
  localparam logic [31:0] ERRD = 32'hDEADBEEF;

  logic        clk = 1'b0;
  logic        rst;
  logic        cpu_req, cpu_kill;
  logic [31:0] cpu_addr, cpu_wdata;
  logic [3:0]  cpu_we;
  logic [31:0] cpu_rdata;
  logic        cpu_stall, cpu_err;
  logic        bus_req, bus_we;
  logic [31:0] bus_addr, bus_wdata;
  logic [3:0]  bus_be;
  logic        bus_ack = 1'b0, bus_err = 1'b0;
  logic [31:0] bus_rdata = '0;

  always #5 clk = ~clk;

  dmem_bus_responder #(.TIMEOUT(TO), .ERR_RDATA(ERRD)) dut (
    .clk(clk), .rst(rst),
    .cpu_req(cpu_req), .cpu_kill(cpu_kill), .cpu_addr(cpu_addr),
    .cpu_wdata(cpu_wdata), .cpu_we(cpu_we), .cpu_rdata(cpu_rdata),
    .cpu_stall(cpu_stall), .cpu_err(cpu_err),
    .bus_req(bus_req), .bus_we(bus_we), .bus_addr(bus_addr),
    .bus_be(bus_be), .bus_wdata(bus_wdata),
    .bus_ack(bus_ack), .bus_err(bus_err), .bus_rdata(bus_rdata)
  );

  typedef struct { int delay; bit err; bit both; } cfg_t;
  typedef struct { logic we; logic [31:0] addr; logic [3:0] be; logic [31:0] wdata; } txn_t;

  int checks = 0, errors = 0;
  int cyc = 0;
  int errSeen = 0, errExp = 0, unstable = 0;
  int wrFreeAt = 0;
  bit spurious = 0;
  cfg_t cfgQ[$];
  txn_t expTxn[$], obsTxn[$];
  logic [31:0] mem    [bit [31:0]];
  logic [31:0] refMem [bit [31:0]];

  task automatic check(input string tag, input logic [71:0] obs, input logic [71:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] initVal(input logic [31:0] a);
    return a * 32'h9E3779B1 + 32'h1357;
  endfunction

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] d,
                                        input logic [3:0] be);
    logic [31:0] r;
    r = old;
    for (int b = 0; b < 4; b++) if (be[b]) r[8*b +: 8] = d[8*b +: 8];
    return r;
  endfunction

  function automatic logic [31:0] memRd(input logic [31:0] a);
    return mem.exists(a) ? mem[a] : initVal(a);
  endfunction

  function automatic logic [31:0] refRd(input logic [31:0] a);
    return refMem.exists(a) ? refMem[a] : initVal(a);
  endfunction

  // cycle counter: value seen after a posedge names the current cycle
  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // count cpu_err high cycles
  initial forever begin
    @(negedge clk);
    if (cpu_err === 1'b1) errSeen++;
  end

  // bus slave with its own memory; config per transaction in issue order
  initial begin
    int   busCycle;
    cfg_t cur;
    txn_t curT;
    busCycle = 0;
    cur = '{0, 1'b0, 1'b0};
    forever begin
      @(negedge clk);
      bus_ack   = 1'b0;
      bus_err   = 1'b0;
      bus_rdata = $urandom();
      if (bus_req === 1'b1 && rst === 1'b0) begin
        busCycle++;
        if (busCycle == 1) begin
          curT = '{bus_we, bus_addr, bus_be, bus_we ? bus_wdata : 32'h0};
          obsTxn.push_back(curT);
          if (cfgQ.size() > 0) cur = cfgQ.pop_front();
          else cur = '{0, 1'b0, 1'b0};
        end else if (bus_we !== curT.we || bus_addr !== curT.addr || bus_be !== curT.be ||
                     (bus_we && bus_wdata !== curT.wdata)) begin
          unstable++;
        end
        if (busCycle == cur.delay) begin
          bus_ack = !cur.err || cur.both;
          bus_err = cur.err;
          if (!cur.err) begin
            if (bus_we) mem[bus_addr] = merge(memRd(bus_addr), bus_wdata, bus_be);
            else bus_rdata = memRd(bus_addr);
          end
        end
      end else begin
        busCycle = 0;
        if (spurious) begin
          bus_ack  = 1'b1;
          spurious = 0;
        end
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  // delay 0 = never ack (timeout). Called at posedge+1, returns at posedge+1.
  task automatic access(input string tag, input bit store, input logic [31:0] addr,
                        input logic [3:0] be, input logic [31:0] data, input int delay,
                        input bit berr, input bit both, input bit lateKill);
    int p, s, d, expStall, stalls;
    bit fail, done;
    logic [31:0] expData, wa;
    wa = {addr[31:2], 2'b00};
    p = cyc;
    s = (wrFreeAt > p) ? wrFreeAt : p;
    d = (delay == 0) ? TO : delay;
    fail = berr || (delay == 0);
    expData = '0;
    cfgQ.push_back('{delay, berr, both});
    expTxn.push_back('{store, wa, store ? be : 4'hF, store ? data : 32'h0});
    if (store) begin
      expStall = s - p;
      wrFreeAt = s + d + 1;
      if (!fail) refMem[wa] = merge(refRd(wa), data, be);
    end else begin
      expStall = s - p + d + 1;
      expData  = fail ? ERRD : refRd(wa);
    end
    if (fail) errExp++;
    cpu_req = 1'b1; cpu_kill = 1'b0; cpu_addr = addr;
    cpu_we = store ? be : 4'b0000; cpu_wdata = data;
    stalls = 0;
    done = 0;
    for (int i = 0; i < 64 && !done; i++) begin
      @(negedge clk);
      if (cpu_stall === 1'b1) begin
        stalls++;
        @(posedge clk); #1;
        if (lateKill && stalls == 1) cpu_kill = 1'b1;
      end else begin
        done = 1;
      end
    end
    check({tag, " done"}, done, 1);
    check({tag, " stalls"}, stalls, expStall);
    if (!store) begin
      check({tag, " rdata"}, cpu_rdata, expData);
      check({tag, " err"}, cpu_err, fail);
    end
    @(posedge clk); #1;
    cpu_req = 1'b0; cpu_kill = 1'b0; cpu_we = 4'b0000;
  endtask

  task automatic idle(input int n);
    cpu_req = 1'b0;
    repeat (n) begin @(posedge clk); #1; end
  endtask

  initial begin
    int nTx;
    rst = 1'b1; cpu_req = 1'b0; cpu_kill = 1'b0;
    cpu_addr = '0; cpu_wdata = '0; cpu_we = '0;
    repeat (3) @(posedge clk);
    #1;
    check("reset outs", {cpu_rdata, cpu_stall, cpu_err, bus_req, bus_we, bus_be},
          {32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 4'h0});
    check("reset bus addr/wdata", {bus_addr, bus_wdata}, 64'h0);
    rst = 1'b0;
    idle(1);

    // 1: load, ack in the third bus cycle
    mem[32'h100] = 32'hCAFEF00D; refMem[32'h100] = 32'hCAFEF00D;
    access("t1 load", 0, 32'h100, 4'h0, 32'h0, 3, 0, 0, 0);

    // 2: half-word store then load of the same word behind it
    access("t2 store", 1, 32'h206, 4'b0011, 32'h1234, 4, 0, 0, 0);
    @(negedge clk);
    check("t2 bus fields", {bus_req, bus_we, bus_addr, bus_be, bus_wdata},
          {1'b1, 1'b1, 32'h204, 4'b0011, 32'h1234});
    @(posedge clk); #1;
    access("t2 load", 0, 32'h204, 4'h0, 32'h0, 1, 0, 0, 0);

    // 3: back-to-back stores, ack two cycles late
    access("t3 st1", 1, 32'h300, 4'hF, 32'h11112222, 3, 0, 0, 0);
    access("t3 st2", 1, 32'h304, 4'hF, 32'h33334444, 3, 0, 0, 0);
    idle(5);

    // 4: load timeout, then store with bus error
    access("t4 timeout", 0, 32'h308, 4'h0, 32'h0, 0, 0, 0, 0);
    access("t4 st err", 1, 32'h30C, 4'hF, 32'h55556666, 2, 1, 0, 0);
    idle(4);
    check("t4 err pulses", errSeen, errExp);
    access("t4 st after err", 1, 32'h30C, 4'h1, 32'h000000AA, 1, 0, 0, 0);
    idle(3);

    // 5: killed request, late kill, reset during RD_WAIT
    cpu_req = 1'b1; cpu_kill = 1'b1; cpu_we = 4'h0; cpu_addr = 32'h500;
    @(negedge clk);
    check("t5 kill stall", cpu_stall, 0);
    @(posedge clk); #1;
    @(negedge clk);
    check("t5 kill bus_req", bus_req, 0);
    @(posedge clk); #1;
    cpu_req = 1'b0; cpu_kill = 1'b0;
    access("t5 late kill", 0, 32'h100, 4'h0, 32'h0, 3, 0, 0, 1);
    cfgQ.push_back('{0, 1'b0, 1'b0});
    expTxn.push_back('{1'b0, 32'h400, 4'hF, 32'h0});
    cpu_req = 1'b1; cpu_we = 4'h0; cpu_addr = 32'h400;
    repeat (3) begin @(posedge clk); #1; end
    rst = 1'b1; cpu_req = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check("t5 rst bus_req/stall/err", {bus_req, cpu_stall, cpu_err}, 3'b000);
    check("t5 rst rdata", cpu_rdata, 32'h0);
    wrFreeAt = 0;
    @(posedge clk); #1;

    // 6: ack with err on a load; spurious ack while idle
    access("t6 ack+err", 0, 32'h104, 4'h0, 32'h0, 2, 1, 1, 0);
    spurious = 1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    @(negedge clk);
    check("t6 spurious", {bus_req, cpu_stall, cpu_err}, 3'b000);
    check("t6 spurious rdata", cpu_rdata, ERRD);
    @(posedge clk); #1;

    // 7: random traffic against the reference memory
    for (int n = 0; n < 40; n++) begin
      int r, dl;
      bit st;
      logic [31:0] a;
      r  = $urandom_range(0, 19);
      dl = (r == 0) ? 0 : $urandom_range(1, TO - 1);
      st = $urandom_range(0, 1) == 1;
      a  = 32'h600 + ($urandom_range(0, 7) << 2) + $urandom_range(0, 3);
      access("rnd", st, a, st ? 4'($urandom_range(1, 15)) : 4'h0, $urandom(),
             dl, r == 1 || r == 2, r == 2, 0);
      idle($urandom_range(0, 2));
    end
    idle(12);

    check("err pulse total", errSeen, errExp);
    check("bus stability", unstable, 0);
    check("txn count", obsTxn.size(), expTxn.size());
    nTx = (obsTxn.size() < expTxn.size()) ? obsTxn.size() : expTxn.size();
    for (int i = 0; i < nTx; i++) begin
      check("txn", {obsTxn[i].we, obsTxn[i].addr, obsTxn[i].be, obsTxn[i].wdata},
            {expTxn[i].we, expTxn[i].addr, expTxn[i].be, expTxn[i].wdata});
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
